maze_move_ctrl: RTL and testbench

Game-flow controller that drives the player block. It turns level-sensitive n8 controller buttons into rate-limited, single-cycle move/action strobes with auto-repeat. It also runs the round state machine (idle, play, respawn, game over, win), tracks lives, and issues the player-block reset pulse for spawn and respawn. It sits between the controller reader and the player block; lava and goal detectors feed it hit flags.

---
 rtl/maze_move_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_maze_move_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl: game-flow controller for the player block.
// Turns raw controller button levels into single-cycle move/action strobes
// with auto-repeat, runs the round state machine (IDLE/PLAY/DEAD/OVER/WIN),
// tracks lives and pulses the player-block reset on spawn and respawn.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   left, up, down, right      raw direction button levels
//   press_A                    raw A button level
//   frame_tick                 one-cycle pulse per video frame
//   lava_hit, goal_hit         hit flags from the cell detectors (levels)
//   mv_left/up/down/right, mv_A  single-cycle strobes to the player block
//   player_rst                 one-cycle spawn reset to the player block
//   gameover, win              high in OVER / WIN
//   lives                      remaining lives
//   state                      IDLE=0, PLAY=1, DEAD=2, OVER=3, WIN=4
module maze_move_ctrl #(
  parameter int unsigned REPEAT_DELAY = 20,
  parameter int unsigned REPEAT_RATE  = 8,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned DEAD_FRAMES  = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       up,
  input  logic       down,
  input  logic       right,
  input  logic       press_A,
  input  logic       frame_tick,
  input  logic       lava_hit,
  input  logic       goal_hit,
  output logic       mv_left,
  output logic       mv_up,
  output logic       mv_down,
  output logic       mv_right,
  output logic       mv_A,
  output logic       player_rst,
  output logic       gameover,
  output logic       win,
  output logic [2:0] lives,
  output logic [2:0] state
);

  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = (REP_MAX < 2) ? 1 : $clog2(REP_MAX + 1);
  localparam int unsigned DEAD_W  = (DEAD_FRAMES < 2) ? 1 : $clog2(DEAD_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_DEAD = 3'd2,
    S_OVER = 3'd3,
    S_WIN  = 3'd4
  } state_t;

  state_t            r_state;
  logic [2:0]        r_lives;
  logic [DEAD_W-1:0] r_dead_cnt;
  logic [REP_W-1:0]  r_rep_cnt;
  logic              r_armed;
  logic [3:0]        r_prev_dir;
  logic              r_prev_a;
  logic [3:0]        r_mv;
  logic              r_mv_a;
  logic              r_player_rst;
  logic              r_gameover;
  logic              r_win;

  // Direction decode: bit0 left, bit1 up, bit2 down, bit3 right
  logic [3:0] w_dir_raw;
  logic       w_dir_valid;
  logic [3:0] w_dir;
  logic       w_dir_new;
  logic       w_in_play;
  logic       w_rep_due;
  logic       w_rep_fire;
  logic       w_dir_fire;
  logic       w_a_rise;
  logic       w_a_fire;

  assign w_dir_raw   = {right, down, up, left};
  assign w_dir_valid = $onehot(w_dir_raw);
  assign w_dir       = w_dir_valid ? w_dir_raw : 4'b0000;
  assign w_dir_new   = w_dir_valid && (w_dir != r_prev_dir);
  assign w_in_play   = (r_state == S_PLAY);

  // The tick that takes the counter from 1 to 0 is the one that fires
  assign w_rep_due   = (r_rep_cnt <= REP_W'(1));
  assign w_rep_fire  = w_dir_valid && !w_dir_new && r_armed && frame_tick && w_rep_due;
  assign w_dir_fire  = w_in_play && (w_dir_new || w_rep_fire);

  assign w_a_rise    = press_A && !r_prev_a;
  assign w_a_fire    = w_in_play && w_a_rise && (w_dir_raw == 4'b0000);

  // Button tracking, auto-repeat and round state machine
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lives      <= 3'(LIVES);
      r_dead_cnt   <= '0;
      r_rep_cnt    <= '0;
      r_armed      <= 1'b0;
      r_prev_dir   <= 4'b0000;
      r_prev_a     <= 1'b0;
      r_mv         <= 4'b0000;
      r_mv_a       <= 1'b0;
      r_player_rst <= 1'b0;
      r_gameover   <= 1'b0;
      r_win        <= 1'b0;
    end else begin
      r_prev_dir   <= w_dir;
      r_prev_a     <= press_A;
      r_player_rst <= 1'b0;

      // Repeat only runs for a press that was seen in PLAY, so a button held
      // across a spawn stays silent until it is released and pressed again
      if (!w_dir_valid) begin
        r_rep_cnt <= '0;
        r_armed   <= 1'b0;
      end else if (w_dir_new) begin
        r_rep_cnt <= REP_W'(REPEAT_DELAY);
        r_armed   <= w_in_play;
      end else if (!w_in_play) begin
        r_armed   <= 1'b0;
      end else if (frame_tick && r_armed) begin
        if (w_rep_due) r_rep_cnt <= REP_W'(REPEAT_RATE);
        else           r_rep_cnt <= r_rep_cnt - REP_W'(1);
      end

      r_mv   <= w_dir_fire ? w_dir : 4'b0000;
      r_mv_a <= w_a_fire;

      case (r_state)
        S_IDLE: begin
          if (w_a_rise) begin
            r_state      <= S_PLAY;
            r_lives      <= 3'(LIVES);
            r_player_rst <= 1'b1;
          end
        end
        S_PLAY: begin
          // Lava wins over a simultaneous goal
          if (lava_hit) begin
            if (r_lives <= 3'd1) begin
              r_lives    <= 3'd0;
              r_state    <= S_OVER;
              r_gameover <= 1'b1;
            end else begin
              r_lives    <= r_lives - 3'd1;
              r_state    <= S_DEAD;
              r_dead_cnt <= DEAD_W'(DEAD_FRAMES);
            end
          end else if (goal_hit) begin
            r_state <= S_WIN;
            r_win   <= 1'b1;
          end
        end
        S_DEAD: begin
          if (frame_tick) begin
            if (r_dead_cnt <= DEAD_W'(1)) begin
              r_dead_cnt   <= '0;
              r_state      <= S_PLAY;
              r_player_rst <= 1'b1;
            end else begin
              r_dead_cnt <= r_dead_cnt - DEAD_W'(1);
            end
          end
        end
        S_OVER, S_WIN: begin
          if (w_a_rise) begin
            r_state    <= S_IDLE;
            r_lives    <= 3'(LIVES);
            r_gameover <= 1'b0;
            r_win      <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_lives    <= 3'(LIVES);
          r_gameover <= 1'b0;
          r_win      <= 1'b0;
        end
      endcase
    end
  end

  assign mv_left    = r_mv[0];
  assign mv_up      = r_mv[1];
  assign mv_down    = r_mv[2];
  assign mv_right   = r_mv[3];
  assign mv_A       = r_mv_a;
  assign player_rst = r_player_rst;
  assign gameover   = r_gameover;
  assign win        = r_win;
  assign lives      = r_lives;
  assign state      = r_state;

endmodule

// File: tb/tb_maze_move_ctrl.sv
// tb_maze_move_ctrl: directed scenarios plus randomized stimulus for
// maze_move_ctrl, every cycle compared against a behavioural model of the
// game rules (hold-time counting for auto-repeat, tick counting for respawn).
module tb_maze_move_ctrl;

  localparam int unsigned DLY    = 20;
  localparam int unsigned RATE   = 8;
  localparam int unsigned NLIVES = 3;
  localparam int unsigned DEADF  = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, left, up, down, right, press_A, frame_tick, lava_hit, goal_hit;
  logic       mv_left, mv_up, mv_down, mv_right, mv_A, player_rst, gameover, win;
  logic [2:0] lives, state;

  maze_move_ctrl #(
    .REPEAT_DELAY(DLY),
    .REPEAT_RATE (RATE),
    .LIVES       (NLIVES),
    .DEAD_FRAMES (DEADF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .left      (left),
    .up        (up),
    .down      (down),
    .right     (right),
    .press_A   (press_A),
    .frame_tick(frame_tick),
    .lava_hit  (lava_hit),
    .goal_hit  (goal_hit),
    .mv_left   (mv_left),
    .mv_up     (mv_up),
    .mv_down   (mv_down),
    .mv_right  (mv_right),
    .mv_A      (mv_A),
    .player_rst(player_rst),
    .gameover  (gameover),
    .win       (win),
    .lives     (lives),
    .state     (state)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model state: game state as plain integers
  int m_state, m_lives, m_prev_dir, m_prev_a, m_armed, m_held, m_dead;
  int e_mv, e_prst;
  int n_right, n_down;

  function automatic void model_reset();
    m_state = 0; m_lives = int'(NLIVES);
    m_prev_dir = 0; m_prev_a = 0; m_armed = 0; m_held = 0; m_dead = 0;
    e_mv = 0; e_prst = 0;
  endfunction

  function automatic void model_update();
    int nd, dirs, dir, a_rise, in_play, fire;
    if (reset) begin
      model_reset();
      return;
    end
    nd      = int'(left) + int'(up) + int'(down) + int'(right);
    dirs    = {28'd0, right, down, up, left};
    dir     = (nd == 1) ? dirs : 0;
    a_rise  = (press_A && m_prev_a == 0) ? 1 : 0;
    in_play = (m_state == 1) ? 1 : 0;
    fire    = 0;
    // Auto-repeat expressed as frames held since the press
    if (dir == 0) begin
      m_armed = 0; m_held = 0;
    end else if (dir != m_prev_dir) begin
      fire = in_play; m_armed = in_play; m_held = 0;
    end else if (in_play == 0) begin
      m_armed = 0;
    end else if (frame_tick && m_armed != 0) begin
      m_held++;
      if (m_held == int'(DLY) ||
          (m_held > int'(DLY) && ((m_held - int'(DLY)) % int'(RATE)) == 0)) fire = 1;
    end
    e_mv = (fire != 0) ? dir : 0;
    if (in_play != 0 && a_rise != 0 && nd == 0) e_mv = e_mv + 16;
    e_prst = 0;
    case (m_state)
      0: if (a_rise != 0) begin m_state = 1; m_lives = int'(NLIVES); e_prst = 1; end
      1: begin
        if (lava_hit) begin
          m_lives = m_lives - 1;
          m_state = (m_lives == 0) ? 3 : 2;
          m_dead  = 0;
        end else if (goal_hit) begin
          m_state = 4;
        end
      end
      2: if (frame_tick) begin
        m_dead++;
        if (m_dead == int'(DEADF)) begin m_state = 1; e_prst = 1; end
      end
      default: if (a_rise != 0) begin m_state = 0; m_lives = int'(NLIVES); end
    endcase
    m_prev_dir = dir;
    m_prev_a   = int'(press_A);
  endfunction

  // One clock: model consumes the sampled inputs, outputs checked 1 ns later
  task automatic step();
    int mv;
    @(posedge clk);
    model_update();
    #1;
    mv = int'({mv_A, mv_right, mv_down, mv_up, mv_left});
    chk("strobes", mv, e_mv);
    chk("player_rst", int'(player_rst), e_prst);
    chk("state", int'(state), m_state);
    chk("lives", int'(lives), m_lives);
    chk("gameover", int'(gameover), (m_state == 3) ? 1 : 0);
    chk("win", int'(win), (m_state == 4) ? 1 : 0);
    chk("strobe_excl", (player_rst && mv != 0) ? 1 : 0, 0);
    chk("strobe_single", $countones(mv[4:0]) <= 1 ? 1 : 0, 1);
    if (mv_right) n_right++;
    if (mv_down)  n_down++;
  endtask

  task automatic run(input int n, input int tick_every);
    for (int i = 0; i < n; i++) begin
      frame_tick = (tick_every > 0 && (i % tick_every) == tick_every - 1);
      step();
    end
    frame_tick = 1'b0;
  endtask

  task automatic tap_a();
    press_A = 1'b1; step();
    press_A = 1'b0; step();
  endtask

  initial begin
    int pick;
    reset = 1'b1; left = 1'b0; up = 1'b0; down = 1'b0; right = 1'b0;
    press_A = 1'b0; frame_tick = 1'b0; lava_hit = 1'b0; goal_hit = 1'b0;
    model_reset();
    n_right = 0; n_down = 0;

    step(); step();
    chk("reset_state", int'(state), 0);
    chk("reset_lives", int'(lives), 3);
    reset = 1'b0;
    step();

    // Spawn from IDLE: PLAY, player_rst, no mv_A
    press_A = 1'b1; step(); press_A = 1'b0;
    chk("spawn_state", int'(state), 1);
    chk("spawn_prst", int'(player_rst), 1);
    chk("spawn_no_A", int'(mv_A), 0);
    chk("spawn_lives", int'(lives), 3);
    step();
    chk("spawn_prst_width", int'(player_rst), 0);

    // Hold right for 40 frame ticks: press + ticks 20, 28, 36
    n_right = 0;
    right = 1'b1; run(160, 4); right = 1'b0; step();
    chk("repeat_count", n_right, 4);

    // Two directions held: silent; releasing one fires the other
    left = 1'b1; up = 1'b1; run(20, 4);
    up = 1'b0; step();
    chk("left_after_release", int'(mv_left), 1);
    step();
    chk("left_width", int'(mv_left), 0);
    left = 1'b0; step();

    // Three lava hits, each followed by the respawn pause
    for (int k = 0; k < 3; k++) begin
      lava_hit = 1'b1; step(); lava_hit = 1'b0;
      chk("lava_lives", int'(lives), 2 - k);
      run(64, 2);
      chk("lava_state", int'(state), (k == 2) ? 3 : 1);
    end
    chk("gameover_flag", int'(gameover), 1);
    tap_a();
    chk("over_to_idle", int'(state), 0);
    chk("over_lives_reload", int'(lives), 3);
    tap_a();
    chk("respawn_play", int'(state), 1);

    // Lava and goal together: lava wins
    lava_hit = 1'b1; goal_hit = 1'b1; step();
    lava_hit = 1'b0; goal_hit = 1'b0;
    chk("lava_prio_state", int'(state), 2);
    chk("lava_prio_lives", int'(lives), 2);
    chk("lava_prio_win", int'(win), 0);
    run(64, 2);
    chk("lava_prio_back", int'(state), 1);

    // Win, back to IDLE, then hold down across the spawn
    goal_hit = 1'b1; step(); goal_hit = 1'b0;
    chk("win_state", int'(state), 4);
    chk("win_flag", int'(win), 1);
    tap_a();
    chk("win_to_idle", int'(state), 0);
    n_down = 0;
    down = 1'b1; run(4, 0);
    press_A = 1'b1; step(); press_A = 1'b0;
    chk("held_spawn_state", int'(state), 1);
    run(40, 4);
    chk("held_no_down", n_down, 0);
    down = 1'b0; step();
    down = 1'b1; step();
    chk("down_repress", int'(mv_down), 1);
    down = 1'b0; step();

    // Reset while in DEAD
    lava_hit = 1'b1; step(); lava_hit = 1'b0;
    chk("dead_before_reset", int'(state), 2);
    run(6, 2);
    reset = 1'b1; step(); reset = 1'b0;
    chk("reset_in_dead_state", int'(state), 0);
    chk("reset_in_dead_lives", int'(lives), 3);

    // Randomized play against the model
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 119) == 0) begin
        pick = int'($urandom_range(0, 9));
        if (pick == 0) {right, down, up, left} = 4'b0000;
        else if (pick == 1) {right, down, up, left} = 4'($urandom_range(0, 15));
        else {right, down, up, left} = 4'b0001 << $urandom_range(0, 3);
      end
      if ($urandom_range(0, 15) == 0) press_A = ~press_A;
      frame_tick = ($urandom_range(0, 2) == 0);
      lava_hit   = ($urandom_range(0, 149) == 0);
      goal_hit   = ($urandom_range(0, 399) == 0);
      reset      = ($urandom_range(0, 1999) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
